uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the scope's host link. It accepts 8N1 asynchronous serial data on an input pin, samples each bit at its centre, and delivers each received byte on a parallel bus with a one-cycle strobe. Error pulses report framing and (optionally) parity faults. It is the receive counterpart of the transmit path and sits between the RXD pin and the command decoder.

## Interface
- CLKS_PER_BIT, default 5208: clock cycles per bit period (50 MHz → 9600 baud); must be ≥ 4.
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-low.
- RXD  in  1  serial line, asynchronous to clk; idles high.
- data  out  8  last correctly framed byte, LSB received first.
- valid  out  1  one-cycle pulse when `data` is updated.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- parity_err  out  1  one-cycle pulse on parity mismatch; tied 0 unless UART_RX_PARITY_EN is defined.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- RXD passes through a 2-flop synchronizer whose flops reset to 1. Call the synchronized value `rx_s`.
- Baud counter: 15-bit, cleared on every state entry. N = CLKS_PER_BIT, H = N/2 (integer divide).
- IDLE: on `rx_s == 0`, clear the counter and go to START.
- START: when the counter reaches H−1, sample `rx_s`:
  - 0 → go to DATA with bit index 0.
  - 1 → treat as a glitch and return to IDLE with no outputs.
- DATA: every N cycles, sample `rx_s` into the shift register, LSB first. After bit index 7 is sampled, go to PARITY if enabled, otherwise to STOP.
- PARITY (macro only): after N cycles, sample the parity bit and compare it with the even parity of the 8 data bits. Store the result, then go to STOP.
- STOP: after N cycles, sample `rx_s`:
  - 1 → load `data` from the shift register, pulse `valid`, pulse `parity_err` if the parity mismatch flag is set, and go to IDLE.
  - 0 → pulse `frame_err`, leave `data` unchanged, and go to BREAK.
- BREAK: wait until `rx_s == 1`, then go to IDLE. A line held low (break) yields exactly one `frame_err`, not repeated frames.
- `valid` and `frame_err` are never high in the same cycle. A byte with a parity error still updates `data` and asserts `valid`.
- There is no backpressure: the consumer must capture `data` on `valid`. `data` holds its value until the next good frame.

## Timing
- Reset values: `data` = 0x00, `valid` = 0, `frame_err` = 0, `parity_err` = 0, `busy` = 0, FSM in IDLE, synchronizer = 1.
- Reset has priority over everything. Asserting reset mid-frame abandons the frame with no pulses.
- t0 is the first cycle in which `rx_s` is sampled low in IDLE. `rx_s` lags the pin by 2 cycles.
- Start sample occurs at t0+H. Data bit k is sampled at t0+H+(k+1)·N.
- Stop sample occurs at t0+H+9N (t0+H+10N with parity).
- `valid` / `frame_err` / `parity_err` are registered high in the cycle after the stop sample.
- `busy` rises the cycle after t0 and falls together with the `valid` pulse, or on exit from BREAK.
- Back-to-back frames: a new start edge is recognized in IDLE immediately after STOP. The receiver tolerates a stop bit as short as H+1 cycles.

## Configuration
- UART_RX_PARITY_EN defined: frame is 8E1 (11 bits), the PARITY state exists, and `parity_err` is live.
- UART_RX_PARITY_EN undefined: frame is 8N1, the PARITY state is removed, and `parity_err` is constant 0.

## Structure
- Shared package/include `uart_pkg`:
  - state encodings (IDLE, START, DATA, PARITY, STOP, BREAK)
  - default CLKS_PER_BIT (5208)
  - the baud-counter width constant (15), shared with the transmitter.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with synchronous active-low reset to 1.

## Test plan
Run with CLKS_PER_BIT = 16 in simulation.
- Send 0xA5 (8N1) → one `valid` pulse at t0+8+144+1, `data` = 0xA5, no error pulses, `busy` low afterward.
- Hold RXD low for 4 cycles, then high → no `valid`, no `frame_err`; FSM returns to IDLE at t0+8.
- Send 0x3C with the stop bit low, then hold RXD low for 100 cycles → exactly one `frame_err`, `data` keeps its previous value, `busy` stays high until RXD returns high.
- Send 0x00 then 0xFF back-to-back with stop bits of exactly 16 cycles → two `valid` pulses, with `data` = 0x00 then 0xFF.
- Assert reset during bit 4 of 0x81, release it, then send 0x81 → all outputs 0 during reset, no pulse for the aborted frame, then `valid` with `data` = 0x81.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 → `valid`, `data` = 0x07, `parity_err` pulse in the same cycle. Send it with parity 1 → `valid` and no `parity_err`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encodings, default bit period, baud-counter width
// and the even-parity helper used by the receiver (and the transmitter).
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 5208;
  localparam int UART_CNT_W        = 15;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RXD pin; both flops reset to the
// idle level (1) so no false start bit is seen coming out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // next-state: shift the pin through the two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // synchronizer flops, synchronous active-low reset to idle-high
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Centre-sampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for
// 8E1 framing with a live parity_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RXD,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [UART_CNT_W-1:0] FULL_LAST = UART_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [UART_CNT_W-1:0] HALF_LAST = UART_CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic                  rx_s;
  logic [2:0]            state_q, state_d;
  logic [UART_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_bad_q, par_bad_d;
  logic                  parity_err_q, parity_err_d;
`endif

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (RXD),
    .q   (rx_s)
  );

  // frame FSM: counter free-runs within a state and is cleared on every entry
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + UART_CNT_W'(1'b1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          // a start bit that is already high again at its centre is a glitch
          if (!rx_s) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          par_bad_d = (rx_s != even_parity(shift_q));
          state_d   = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed and random frames, expected pulses queued
// at stimulus time and checked by an independent monitor.
module tb_uart_rx;

  localparam int N = 16;
  localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB     = 10;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NB     = 9;
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RXD = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .RXD        (RXD),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         ferr;
    bit         perr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] last_good = 8'h00;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every output pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && (valid || frame_err || parity_err)) begin
      chk("valid_frame_excl", {31'd0, valid & frame_err}, 32'd0);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got valid=%b frame_err=%b parity_err=%b, expected none (cycle %0d)",
                 valid, frame_err, parity_err, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("valid",         {31'd0, valid},      {31'd0, ~e.ferr});
        chk("frame_err",     {31'd0, frame_err},  {31'd0, e.ferr});
        chk("parity_err",    {31'd0, parity_err}, {31'd0, e.perr});
        chk("data",          {24'd0, data},       {24'd0, e.data});
        chk("pulse_cycle",   cyc,                 e.cyc);
        chk("busy_at_pulse", {31'd0, busy},       {31'd0, e.ferr});
      end
    end
  end

  task automatic hold(input bit v, input int n);
    RXD = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drives one frame starting now; stop_hi=0 keeps the line low N+low_hold cycles
  task automatic send_frame(input logic [7:0] b, input bit stop_hi, input bit par_bit,
                            input int stop_len, input int low_hold);
    exp_t e;
    e.ferr = !stop_hi;
    e.perr = stop_hi && PAR_EN && (par_bit != (^b));
    e.data = stop_hi ? b : last_good;
    e.cyc  = cyc + 2 + H + NB * N + 1;
    if (stop_hi) last_good = b;
    sb_q.push_back(e);
    hold(1'b0, N);
    for (int i = 0; i < 8; i++) hold(b[i], N);
    if (PAR_EN) hold(par_bit, N);
    if (stop_hi) begin
      hold(1'b1, stop_len);
    end else begin
      hold(1'b0, N + low_hold);
      hold(1'b1, stop_len);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_data"},       {24'd0, data},       {24'd0, last_good});
    chk({tag, "_valid"},      {31'd0, valid},      32'd0);
    chk({tag, "_frame_err"},  {31'd0, frame_err},  32'd0);
    chk({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
    chk({tag, "_busy"},       {31'd0, busy},       32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    bit         good;
    // power-on reset
    rst = 1'b0;
    RXD = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) @(posedge clk); #1;
    check_idle_outputs("post_reset");

    // single good byte
    send_frame(8'hA5, 1'b1, 1'b0, 20, 0);
    check_idle_outputs("after_a5");

    // 4-cycle glitch: START sees the line high at its centre and gives up
    begin
      int e0;
      e0 = cyc;
      hold(1'b0, 4);
      RXD = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("glitch_busy_before", {31'd0, busy}, 32'd1);
      chk("glitch_cycle_ref", cyc, e0 + 10);
      @(negedge clk);
      chk("glitch_busy_after", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      hold(1'b1, 10);
    end

    // stop bit low followed by a long break: one frame_err, busy until line high
    send_frame(8'h3C, 1'b0, 1'b0, 0, 100);
    chk("break_busy_hold", {31'd0, busy}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("break_busy_late", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("break_busy_exit", {31'd0, busy}, 32'd0);
    chk("break_data_kept", {24'd0, data}, {24'd0, last_good});
    @(posedge clk); #1;
    hold(1'b1, 10);

    // back-to-back frames with exact and minimum-length stop bits
    send_frame(8'h00, 1'b1, 1'b1, N, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 20, 0);
    send_frame(8'h5A, 1'b1, 1'b0, H + 1, 0);
    send_frame(8'hC3, 1'b1, 1'b0, 20, 0);

    if (PAR_EN) begin
      send_frame(8'h07, 1'b1, 1'b0, 20, 0);
      send_frame(8'h07, 1'b1, 1'b1, 20, 0);
    end

    // random traffic, occasional framing errors
    for (int k = 0; k < 40; k++) begin
      rb   = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      if (good) begin
        send_frame(rb, 1'b1, 1'($urandom), $urandom_range(N, 40), 0);
      end else begin
        send_frame(rb, 1'b0, 1'($urandom), $urandom_range(20, 40), $urandom_range(0, 30));
      end
    end
    hold(1'b1, 20);

    // reset during bit 4 of 0x81 abandons the frame silently
    hold(1'b0, N);
    hold(1'b1, N);
    hold(1'b0, 3 * N);
    RXD = 1'b0;
    repeat (8) @(posedge clk); #1;
    rst = 1'b0;
    RXD = 1'b1;
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (20) @(posedge clk); #1;
    check_idle_outputs("after_abort");
    send_frame(8'h81, 1'b1, 1'b0, 20, 0);

    // drain, then everything expected must have been seen
    repeat (300) @(posedge clk); #1;
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    check_idle_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
